// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared constants for the load/store unit: access size codes, FSM state
// encoding, response latencies (acceptance edge counted as cycle 1) and the
// alignment rule used at request acceptance.
// -----------------------------------------------------------------------------
package lsu_pkg;

    // Access size codes carried on req_size
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Cycles from the acceptance edge to resp_valid high
    localparam int unsigned LAT_LOAD       = 2;
    localparam int unsigned LAT_STORE_WORD = 2;
    localparam int unsigned LAT_STORE_SUB  = 3;
    localparam int unsigned LAT_ERR        = 1;

    // Natural alignment for each size; the reserved size is always rejected.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = |addr_lo;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// -----------------------------------------------------------------------------
// lsu_lane_align
// Combinational little-endian byte-lane steering for the load/store unit.
//   word_i     : 32-bit memory word (fresh read data or the read buffer)
//   addr_lo_i  : byte offset within the word
//   size_i     : access size code (lsu_pkg SZ_*)
//   signed_i   : sign-extend sub-word loads
//   wdata_i    : right-justified store data
//   load_o     : addressed lane, zero/sign-extended to 32 bits
//   merged_o   : word_i with the addressed lane replaced by store data
//                (wdata_i unchanged for word accesses)
// -----------------------------------------------------------------------------
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merged_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[{addr_lo_i, 3'b000} +: 8];
        half_sel = word_i[{addr_lo_i[1], 4'b0000} +: 16];
        load_o   = word_i;
        merged_o = wdata_i;
        case (size_i)
            SZ_BYTE: begin
                load_o   = {{24{signed_i & byte_sel[7]}}, byte_sel};
                merged_o = word_i;
                merged_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
            end
            SZ_HALF: begin
                load_o   = {{16{signed_i & half_sel[15]}}, half_sel};
                merged_o = word_i;
                merged_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Initiator for a word-wide data memory with a single write enable. Accepts
// byte/half/word loads and stores from the core one at a time; sub-word
// stores are done as read-modify-write.
//
// Ports
//   CLK, rst           : clock (rising edge), synchronous active-high reset
//   req_valid/ready    : request handshake; ready only while idle
//   req_we, req_size   : store flag, size code (00 byte, 01 half, 10 word)
//   req_signed         : sign-extend sub-word loads
//   req_addr, wdata    : byte address, right-justified store data
//   resp_valid         : one-cycle completion pulse
//   resp_rdata/err     : load result / error flag, held until next response
//   mem_A/WE/WD/RD     : word index, write enable, write data, comb. read data
//
// Build option
//   LSU_BOUNDS_CHECK_EN : when defined, word index >= MEM_WORDS is rejected
//                         as an error at acceptance.
// -----------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 32,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [31:0]       mem_A,
    output logic              mem_WE,
    output logic [31:0]       mem_WD,
    input  logic [31:0]       mem_RD
);

`ifdef LSU_BOUNDS_CHECK_EN
    localparam bit BoundsEn = 1'b1;
`else
    localparam bit BoundsEn = 1'b0;
`endif

    logic [1:0]  state_q, state_d;
    logic        we_q, signed_q;
    logic [1:0]  size_q, addr_lo_q;
    logic [31:0] wdata_q, buf_q;
    logic [31:0] mem_a_q, mem_a_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    logic        accept, req_err, oob;
    logic [31:0] align_word, load_val, merged;

    assign req_ready = (state_q == ST_IDLE);
    assign accept    = req_valid && req_ready;

    assign oob     = BoundsEn &&
                     ({2'b00, req_addr[ADDR_W-1:2]} >= ADDR_W'(MEM_WORDS));
    assign req_err = is_misaligned(req_size, req_addr[1:0]) || oob;

    // During READ the load/merge path looks straight at memory so the load
    // result can be registered on the READ->RESP edge; afterwards the
    // captured buffer feeds the RMW merge in WRITE.
    assign align_word = (state_q == ST_READ) ? mem_RD : buf_q;

    lsu_lane_align u_align (
        .word_i    (align_word),
        .addr_lo_i (addr_lo_q),
        .size_i    (size_q),
        .signed_i  (signed_q),
        .wdata_i   (wdata_q),
        .load_o    (load_val),
        .merged_o  (merged)
    );

    always_comb begin
        state_d      = state_q;
        mem_a_d      = mem_a_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        state_d      = ST_RESP;
                        resp_rdata_d = 32'h0;
                        resp_err_d   = 1'b1;
                    end else begin
                        mem_a_d = 32'(req_addr[ADDR_W-1:2]);
                        state_d = (req_we && req_size == SZ_WORD) ? ST_WRITE : ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (we_q) begin
                    state_d = ST_WRITE;
                end else begin
                    state_d      = ST_RESP;
                    resp_rdata_d = load_val;
                    resp_err_d   = 1'b0;
                end
            end
            ST_WRITE: begin
                state_d      = ST_RESP;
                resp_rdata_d = 32'h0;
                resp_err_d   = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and output registers
    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            mem_a_q      <= 32'h0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_a_q      <= mem_a_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Request capture and read buffer: only meaningful once loaded
    always_ff @(posedge CLK) begin
        if (accept) begin
            we_q      <= req_we;
            size_q    <= req_size;
            signed_q  <= req_signed;
            addr_lo_q <= req_addr[1:0];
            wdata_q   <= req_wdata;
        end
        if (state_q == ST_READ) begin
            buf_q <= mem_RD;
        end
    end

    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_A      = mem_a_q;
    // Gated by rst so a reset landing on WRITE never lets the write through.
    assign mem_WE     = (state_q == ST_WRITE) && !rst;
    assign mem_WD     = (state_q == ST_WRITE) ? merged : 32'h0;

endmodule
